// File: rtl/bram_sweep_checker_pkg.sv
// Shared types and helpers for the BRAM read-back sweep checker.
// Holds the sweep state encoding, depth derivation and expected pattern.
package bram_sweep_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Caller truncates to the BRAM word width, giving the mod-2**W wrap.
    function automatic logic [31:0] exp_word(
        input logic [31:0] base,
        input logic [31:0] k
    );
        return base + k;
    endfunction

endpackage

// File: rtl/bram_sweep_checker.sv
// Walks every BRAM address through a read port and checks base+addr.
// Accumulates mismatch count plus first failing address and data.
module bram_sweep_checker
    import bram_sweep_checker_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    output logic                  en,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic                  err_seen,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [DATA_WIDTH-1:0] last_value
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic                  vld_q, vld_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
    logic                  err_seen_q, err_seen_d;
    logic [ADDR_WIDTH-1:0] fea_q, fea_d;
    logic [DATA_WIDTH-1:0] fed_q, fed_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic [DATA_WIDTH-1:0] exp_w;

    assign exp_w = DATA_WIDTH'(exp_word(32'(base_q), 32'(k_q)));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        en_d        = en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_seen_d  = err_seen_q;
        fea_d       = fea_q;
        fed_d       = fed_q;
        last_d      = last_q;
        // Tag the issued address so it lines up with dout next cycle.
        k_d         = addr_q;
        vld_d       = en_q;

        if (vld_q) begin
            last_d = dout;
            if (dout != exp_w) begin
                err_count_d = err_count_q + 1'b1;
                if (!err_seen_q) begin
                    err_seen_d = 1'b1;
                    fea_d      = k_q;
                    fed_d      = dout;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base;
                    err_count_d = '0;
                    err_seen_d  = 1'b0;
                    fea_d       = '0;
                    fed_d       = '0;
                    pass_d      = 1'b0;
                    addr_d      = '0;
                    en_d        = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (addr_q == LAST) begin
                    en_d    = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                done_d  = 1'b1;
                pass_d  = (err_count_d == '0);
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            k_q         <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_seen_q  <= 1'b0;
            fea_q       <= '0;
            fed_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            k_q         <= k_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_seen_q  <= err_seen_d;
            fea_q       <= fea_d;
            fed_q       <= fed_d;
            last_q      <= last_d;
        end
    end

    assign en             = en_q;
    assign we             = 1'b0;
    assign addr           = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign err_seen       = err_seen_q;
    assign first_err_addr = fea_q;
    assign first_err_data = fed_q;
    assign last_value     = last_q;

endmodule

// File: doc/bram_sweep_checker.md
# bram_sweep_checker

Read-back verifier that sits downstream of the BRAM write/test FSM on the 16-bit x 512 dual-port BRAM. On a start pulse it walks every address through one read-only BRAM port. It compares each returned word against an arithmetic expected pattern (base + address) and accumulates a mismatch count plus the first failing address and data. Results feed the board status LEDs and 7-segment display, and run on the same slowed clock as the BRAM.

## Interface
Parameters:
- ADDR_WIDTH, 9, BRAM address width; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 16, BRAM word width

Ports:
- clk  in  1  BRAM/FSM clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a sweep; sampled only in IDLE
- base  in  DATA_WIDTH  pattern base; captured on accepted start
- en  out  1  BRAM port enable
- we  out  1  BRAM write enable; constant 0
- addr  out  ADDR_WIDTH  BRAM read address
- dout  in  DATA_WIDTH  BRAM read data, valid 1 cycle after en
- busy  out  1  high from accepted start through DONE state
- done  out  1  one-cycle pulse at sweep completion
- pass  out  1  1 when last completed sweep had zero mismatches
- err_count  out  ADDR_WIDTH+1  mismatches in last/current sweep
- err_seen  out  1  at least one mismatch recorded
- first_err_addr  out  ADDR_WIDTH  address of first mismatch
- first_err_data  out  DATA_WIDTH  data read at first mismatch
- last_value  out  DATA_WIDTH  most recent word compared (for display)

## Operation
- States: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
- IDLE: en=0. When start=1, capture base, clear err_count, err_seen, first_err_*, pass; set addr=0 and en=1; go to SWEEP.
- SWEEP: each cycle issue addr, en=1, and compare the word for addr-1 (pipelined). After issuing address DEPTH-1, drop en and go to DRAIN.
- DRAIN: compare the final word (address DEPTH-1). Go to DONE.
- DONE: done=1, pass=(err_count==0) registered; busy still 1. Go to IDLE.
- Compare: expected = (base_q + k) mod 2**DATA_WIDTH, with k zero-extended. Mismatch increments err_count. On the first mismatch, load first_err_addr=k and first_err_data=dout, and set err_seen.
- err_count cannot exceed DEPTH, so its width is sufficient and no saturation is needed.
- Each compared word updates last_value.
- start while busy is ignored, including in the DONE cycle.
- Results hold after DONE until the next accepted start.
- Reset at any point forces IDLE and all outputs to 0. A sweep in progress is abandoned and not resumed.

## Timing
- Reset values: en, we, addr, busy, done, pass, err_count, err_seen, first_err_addr, first_err_data, last_value are all 0.
- Start accepted at edge T: busy=1, en=1, addr=0 after T.
- Address k is presented after edge T+k.
- Compare for address k occurs at edge T+k+2.
- DRAIN occupies the cycle after T+DEPTH. DONE (done=1) is the cycle after edge T+DEPTH+1.
- busy falls after edge T+DEPTH+2.
- Total: DEPTH+2 busy cycles (514 for default).
- A new start is accepted at the earliest on the first IDLE cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds the state encoding localparams (IDLE, SWEEP, DRAIN, DONE), the DEPTH derivation, and the expected-pattern function (base + addr).
- Single module. Compare/accumulate is an inline one-stage pipeline: a registered address tag k_q plus a valid bit. No sub-module.

## Test plan
- Behavioural BRAM (1-cycle read) preloaded with 0x1234+addr; start, base=0x1234 -> done 514 cycles after start, pass=1, err_count=0, err_seen=0, last_value=0x1433.
- Same image with addr 0x05A=0xDEAD and addr 0x1FF=0x0000 -> err_count=2, first_err_addr=0x05A, first_err_data=0xDEAD, pass=0.
- Preload 0xFFF0+addr (16-bit wrap), base=0xFFF0 -> pass=1. Word at addr 0x010 must be 0x0000.
- Pulse start at cycles 50 and 513 of a running sweep -> ignored. Exactly one done pulse occurs and busy spans 514 cycles.
- Assert rst_n=0 while addr=100 -> all outputs 0 at once. A new start after release completes a full sweep with correct results.
- Check we=0 throughout, en=0 in IDLE, DRAIN and DONE, and addr sequence 0..511 without gaps.
